// File: rtl/sram_access_arbiter_pkg.sv
// Shared definitions for the SRAM access arbiter: FSM state encoding,
// strobe-inactive constants and default geometry/timing parameters.
package sram_access_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W   = 23;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_WAIT_CYC = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2,
        StHold   = 2'd3
    } arb_state_e;

    // All SRAM control strobes are active low.
    localparam logic       STROBE_OFF = 1'b1;
    localparam logic [1:0] LANES_OFF  = 2'b11;
    localparam logic [1:0] LANES_ALL  = 2'b00;

endpackage

// File: rtl/sram_access_arbiter.sv
// Shares the external asynchronous SRAM port between the bootstrap loader
// (write-only) and the micro (read/write). The bootstrap owns the port until
// boot_done_i is seen in IDLE; after that the micro owns it until reset.
// Each access runs IDLE -> SETUP -> ACCESS (WAIT_CYC cycles) -> HOLD with all
// SRAM strobes driven straight from flops so they are glitch-free.
//
// Ports:
//   master_clk_i, master_rst_i      clock, synchronous active-high reset
//   boot_done_i                     hands ownership to the micro (level)
//   bt_req_i/addr/data, bt_ack_o    bootstrap write request / completion pulse
//   mc_req_i/we/addr/data/be        micro request, direction, byte enables
//   mc_ack_o, mc_rdata_o            micro completion pulse, read data
//   sram_*                          SRAM address, data, DQ drive enable, strobes
//   owner_o                         0 = bootstrap, 1 = micro
//   error_o                         sticky: bootstrap request after handover
module sram_access_arbiter
    import sram_access_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned WAIT_CYC = DEF_WAIT_CYC  // 1..15
) (
    input  logic              master_clk_i,
    input  logic              master_rst_i,
    input  logic              boot_done_i,
    input  logic              bt_req_i,
    input  logic [ADDR_W-1:0] bt_addr_i,
    input  logic [DATA_W-1:0] bt_data_i,
    output logic              bt_ack_o,
    input  logic              mc_req_i,
    input  logic              mc_we_i,
    input  logic [ADDR_W-1:0] mc_addr_i,
    input  logic [DATA_W-1:0] mc_data_i,
    input  logic [1:0]        mc_be_i,
    output logic              mc_ack_o,
    output logic [DATA_W-1:0] mc_rdata_o,
    output logic [ADDR_W-1:0] sram_address_o,
    output logic [DATA_W-1:0] sram_data_o,
    input  logic [DATA_W-1:0] sram_data_i,
    output logic              sram_data_oe_o,
    output logic              sram_cs_o,
    output logic              sram_we_o,
    output logic              sram_oe_o,
    output logic [1:0]        sram_lb_ub_o,
    output logic              sram_adv_o,
    output logic              owner_o,
    output logic              error_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYC - 1);

    arb_state_e state;
    logic [3:0] wait_cnt;
    logic       acc_boot;   // access belongs to the bootstrap
    logic       acc_write;  // access direction
    logic       acc_live;   // 0 for a micro access with no byte lanes enabled
    logic       owner_next;
    logic       mc_noop;

    // Ownership is one-way: once the micro owns the port it keeps it.
    assign owner_next = owner_o | boot_done_i;
    assign mc_noop    = (mc_be_i == 2'b00);

    always_ff @(posedge master_clk_i) begin
        if (master_rst_i) begin
            state          <= StIdle;
            wait_cnt       <= '0;
            acc_boot       <= 1'b0;
            acc_write      <= 1'b0;
            acc_live       <= 1'b0;
            bt_ack_o       <= 1'b0;
            mc_ack_o       <= 1'b0;
            mc_rdata_o     <= '0;
            sram_address_o <= '0;
            sram_data_o    <= '0;
            sram_data_oe_o <= 1'b0;
            sram_cs_o      <= STROBE_OFF;
            sram_we_o      <= STROBE_OFF;
            sram_oe_o      <= STROBE_OFF;
            sram_lb_ub_o   <= LANES_OFF;
            sram_adv_o     <= STROBE_OFF;
            owner_o        <= 1'b0;
            error_o        <= 1'b0;
        end else begin
            bt_ack_o <= 1'b0;
            mc_ack_o <= 1'b0;

            // A bootstrap request after handover is a protocol error and is never served.
            if (bt_req_i && (owner_o || (state == StIdle && boot_done_i))) begin
                error_o <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    owner_o <= owner_next;
                    if (!owner_next && bt_req_i) begin
                        state          <= StSetup;
                        acc_boot       <= 1'b1;
                        acc_write      <= 1'b1;
                        acc_live       <= 1'b1;
                        sram_address_o <= bt_addr_i;
                        sram_data_o    <= bt_data_i;
                        sram_data_oe_o <= 1'b1;
                        sram_lb_ub_o   <= LANES_ALL;
                        sram_cs_o      <= 1'b0;
                        sram_adv_o     <= 1'b0;
                    end else if (owner_next && mc_req_i) begin
                        // No enabled lanes: run the normal timing so the ack arrives,
                        // but never select the chip.
                        state          <= StSetup;
                        acc_boot       <= 1'b0;
                        acc_write      <= mc_we_i;
                        acc_live       <= !mc_noop;
                        sram_address_o <= mc_addr_i;
                        sram_data_o    <= mc_data_i;
                        sram_data_oe_o <= mc_we_i && !mc_noop;
                        sram_lb_ub_o   <= ~mc_be_i;
                        sram_cs_o      <= mc_noop ? STROBE_OFF : 1'b0;
                        sram_adv_o     <= mc_noop ? STROBE_OFF : 1'b0;
                    end
                end
                StSetup: begin
                    state      <= StAccess;
                    wait_cnt   <= WAIT_LOAD;
                    sram_adv_o <= STROBE_OFF;
                    sram_we_o  <= (acc_live && acc_write) ? 1'b0 : STROBE_OFF;
                    sram_oe_o  <= (acc_live && !acc_write) ? 1'b0 : STROBE_OFF;
                end
                StAccess: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= StHold;
                        sram_we_o <= STROBE_OFF;
                        sram_oe_o <= STROBE_OFF;
                        if (acc_boot) begin
                            bt_ack_o <= 1'b1;
                        end else begin
                            mc_ack_o <= 1'b1;
                        end
                        if (acc_live && !acc_write) begin
                            mc_rdata_o <= sram_data_i;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                StHold: begin
                    // CS and the DQ drive were kept through this cycle so write data
                    // stays valid past the WE rising edge.
                    state          <= StIdle;
                    sram_cs_o      <= STROBE_OFF;
                    sram_data_oe_o <= 1'b0;
                    sram_lb_ub_o   <= LANES_OFF;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
module tb_sram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        boot_done;
    logic        bt_req;
    logic [22:0] bt_addr;
    logic [15:0] bt_data;
    logic        bt_ack;
    logic        mc_req;
    logic        mc_we;
    logic [22:0] mc_addr;
    logic [15:0] mc_data;
    logic [1:0]  mc_be;
    logic        mc_ack;
    logic [15:0] mc_rdata;
    logic [22:0] sram_address;
    logic [15:0] sram_data_out;
    logic [15:0] sram_data_in;
    logic        sram_data_oe;
    logic        sram_cs;
    logic        sram_we;
    logic        sram_oe;
    logic [1:0]  sram_lb_ub;
    logic        sram_adv;
    logic        owner;
    logic        error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_access_arbiter dut (
        .master_clk_i   (clk),
        .master_rst_i   (rst),
        .boot_done_i    (boot_done),
        .bt_req_i       (bt_req),
        .bt_addr_i      (bt_addr),
        .bt_data_i      (bt_data),
        .bt_ack_o       (bt_ack),
        .mc_req_i       (mc_req),
        .mc_we_i        (mc_we),
        .mc_addr_i      (mc_addr),
        .mc_data_i      (mc_data),
        .mc_be_i        (mc_be),
        .mc_ack_o       (mc_ack),
        .mc_rdata_o     (mc_rdata),
        .sram_address_o (sram_address),
        .sram_data_o    (sram_data_out),
        .sram_data_i    (sram_data_in),
        .sram_data_oe_o (sram_data_oe),
        .sram_cs_o      (sram_cs),
        .sram_we_o      (sram_we),
        .sram_oe_o      (sram_oe),
        .sram_lb_ub_o   (sram_lb_ub),
        .sram_adv_o     (sram_adv),
        .owner_o        (owner),
        .error_o        (error)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int we_low;
        int oe_low;
        int cs_low;
        int acks;

        rst          = 1'b1;
        boot_done    = 1'b0;
        bt_req       = 1'b0;
        bt_addr      = '0;
        bt_data      = '0;
        mc_req       = 1'b0;
        mc_we        = 1'b0;
        mc_addr      = '0;
        mc_data      = '0;
        mc_be        = 2'b00;
        sram_data_in = 16'h0000;

        // 1. reset held for three cycles
        repeat (3) step();
        check("rst_cs", 32'(sram_cs), 32'h1);
        check("rst_we", 32'(sram_we), 32'h1);
        check("rst_oe", 32'(sram_oe), 32'h1);
        check("rst_adv", 32'(sram_adv), 32'h1);
        check("rst_lb_ub", 32'(sram_lb_ub), 32'h3);
        check("rst_data_oe", 32'(sram_data_oe), 32'h0);
        check("rst_owner", 32'(owner), 32'h0);
        check("rst_error", 32'(error), 32'h0);
        check("rst_acks", {30'd0, bt_ack, mc_ack}, 32'h0);
        check("rst_address", 32'(sram_address), 32'h0);
        check("rst_rdata", 32'(mc_rdata), 32'h0);
        rst = 1'b0;
        step();

        // 2. bootstrap write: cs low +1..+6, we low +2..+5, ack at +6
        bt_req  = 1'b1;
        bt_addr = 23'h000010;
        bt_data = 16'hA55A;
        for (int k = 1; k <= 8; k++) begin
            step();
            check($sformatf("bt_cs_k%0d", k), 32'(sram_cs), (k >= 1 && k <= 6) ? 32'h0 : 32'h1);
            check($sformatf("bt_we_k%0d", k), 32'(sram_we), (k >= 2 && k <= 5) ? 32'h0 : 32'h1);
            check($sformatf("bt_ack_k%0d", k), 32'(bt_ack), (k == 6) ? 32'h1 : 32'h0);
            if (k == 1) begin
                check("bt_lb_ub", 32'(sram_lb_ub), 32'h0);
                check("bt_data", 32'(sram_data_out), 32'hA55A);
                check("bt_addr", 32'(sram_address), 32'h10);
                check("bt_data_oe", 32'(sram_data_oe), 32'h1);
                check("bt_adv", 32'(sram_adv), 32'h0);
            end
            if (k == 6) begin
                check("bt_hold_data_oe", 32'(sram_data_oe), 32'h1);
                bt_req = 1'b0;
            end
        end

        // 3. micro read stalls while the bootstrap owns the port
        mc_req       = 1'b1;
        mc_we        = 1'b0;
        mc_addr      = 23'h000020;
        mc_be        = 2'b11;
        sram_data_in = 16'h1234;
        cs_low = 0;
        acks   = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (sram_cs == 1'b0) cs_low++;
            if (mc_ack) acks++;
        end
        check("stall_cs_low_cycles", 32'(cs_low), 32'd0);
        check("stall_acks", 32'(acks), 32'd0);
        check("stall_owner", 32'(owner), 32'h0);

        boot_done = 1'b1;
        oe_low = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (sram_oe == 1'b0) oe_low++;
            check($sformatf("rd_ack_k%0d", k), 32'(mc_ack), (k == 6) ? 32'h1 : 32'h0);
            if (k == 1) check("rd_owner", 32'(owner), 32'h1);
            if (k == 6) begin
                check("rd_rdata", 32'(mc_rdata), 32'h1234);
                mc_req = 1'b0;
            end
        end
        check("rd_oe_low_cycles", 32'(oe_low), 32'd4);
        sram_data_in = 16'h0000;
        step();
        check("rd_rdata_held", 32'(mc_rdata), 32'h1234);

        // 5. micro write, upper byte only
        mc_req  = 1'b1;
        mc_we   = 1'b1;
        mc_addr = 23'h000030;
        mc_data = 16'hBEEF;
        mc_be   = 2'b10;
        we_low  = 0;
        acks    = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (sram_we == 1'b0) we_low++;
            if (mc_ack) acks++;
            if (k == 1) begin
                check("wr_lb_ub", 32'(sram_lb_ub), 32'h1);
                check("wr_data", 32'(sram_data_out), 32'hBEEF);
                check("wr_data_oe", 32'(sram_data_oe), 32'h1);
            end
            if (k == 6) begin
                check("wr_ack_k6", 32'(mc_ack), 32'h1);
                mc_req = 1'b0;
            end
            if (k == 7) check("wr_idle_cs", 32'(sram_cs), 32'h1);
        end
        check("wr_we_low_cycles", 32'(we_low), 32'd4);
        check("wr_ack_count", 32'(acks), 32'd1);

        // no-op micro access: acked, chip never selected
        mc_req = 1'b1;
        mc_we  = 1'b0;
        mc_be  = 2'b00;
        cs_low = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (sram_cs == 1'b0) cs_low++;
            check($sformatf("noop_ack_k%0d", k), 32'(mc_ack), (k == 6) ? 32'h1 : 32'h0);
            if (k == 6) mc_req = 1'b0;
        end
        check("noop_cs_low_cycles", 32'(cs_low), 32'd0);

        // 6. reset pulsed in the second ACCESS cycle of a micro write
        mc_req  = 1'b1;
        mc_we   = 1'b1;
        mc_be   = 2'b11;
        mc_data = 16'h0F0F;
        repeat (3) step();
        check("abort_pre_we", 32'(sram_we), 32'h0);
        rst = 1'b1;
        step();
        check("abort_cs", 32'(sram_cs), 32'h1);
        check("abort_we", 32'(sram_we), 32'h1);
        check("abort_owner", 32'(owner), 32'h0);
        rst       = 1'b0;
        mc_req    = 1'b0;
        boot_done = 1'b0;
        acks = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (mc_ack) acks++;
        end
        check("abort_acks", 32'(acks), 32'd0);

        // 4. boot_done rises during a bootstrap ACCESS
        bt_req  = 1'b1;
        bt_addr = 23'h000040;
        bt_data = 16'h1111;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 2) boot_done = 1'b1;
            if (k == 6) begin
                check("handover_bt_ack", 32'(bt_ack), 32'h1);
                check("handover_owner_hold", 32'(owner), 32'h0);
                bt_req = 1'b0;
            end
        end
        check("handover_owner", 32'(owner), 32'h1);
        check("handover_error_clear", 32'(error), 32'h0);

        bt_req  = 1'b1;
        bt_addr = 23'h000050;
        cs_low = 0;
        acks   = 0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (sram_cs == 1'b0) cs_low++;
            if (bt_ack) acks++;
            if (k == 1) check("late_bt_error_k1", 32'(error), 32'h1);
        end
        bt_req = 1'b0;
        step();
        check("late_bt_cs_low_cycles", 32'(cs_low), 32'd0);
        check("late_bt_acks", 32'(acks), 32'd0);
        check("late_bt_error_sticky", 32'(error), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
